led_palette_fader: RTL and testbench

LED_PALETTE_FADER -- requirements
Module: led_palette_fader

---
 rtl/led_pwm_pkg.sv | 43 ++++
 rtl/led_gamma_lut.sv | 43 ++++
 rtl/led_palette_fader.sv | 243 ++++++++++++++++++++++++
 tb/tb_led_palette_fader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pwm_pkg.sv
// ---------------------------------------------------------------------------
// led_pwm_pkg
// Shared types and helpers for the LED palette fader.
//   t_led_byte           : one 8-bit channel value
//   t_fader_state        : fader FSM state encoding
//   c_filament_on_value  : full-brightness channel value
//   c_filament_off_value : dark channel value (also the reset value)
//   step_toward()        : one bounded fade step of a channel toward its target
// ---------------------------------------------------------------------------
package led_pwm_pkg;

  typedef logic [7:0] t_led_byte;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FADE
  } t_fader_state;

  localparam t_led_byte c_filament_on_value  = 8'hFF;
  localparam t_led_byte c_filament_off_value = 8'h00;

  // Move cur toward tgt by at most step. When the remaining gap is no larger
  // than step we land exactly on tgt, so the result can neither overshoot nor
  // wrap past 8'h00 / 8'hFF.
  function automatic t_led_byte step_toward(input t_led_byte cur,
                                            input t_led_byte tgt,
                                            input t_led_byte step);
    t_led_byte gap;
    t_led_byte res;
    res = cur;
    gap = 8'h00;
    if (tgt > cur) begin
      gap = tgt - cur;
      res = (gap > step) ? cur + step : tgt;
    end else if (tgt < cur) begin
      gap = cur - tgt;
      res = (gap > step) ? cur - step : tgt;
    end
    return res;
  endfunction

endpackage

// File: rtl/led_gamma_lut.sv
// ---------------------------------------------------------------------------
// led_gamma_lut
// Registered gamma-2.2 correction of one 8-bit channel (one cycle latency).
// Only instantiated by led_palette_fader when LED_FADER_GAMMA_EN is defined.
//   i_clk   : clock
//   i_srst  : synchronous active-high reset, clears the output to 8'h00
//   i_value : linear channel value
//   o_value : gamma-corrected value, lookup(0)=0 and lookup(255)=255
// ---------------------------------------------------------------------------
module led_gamma_lut
  import led_pwm_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_srst,
  input  t_led_byte i_value,
  output t_led_byte o_value
);

  // x^2.2 on the normalised range is approximated by 0.8*x^2 + 0.2*x^3,
  // evaluated in integers as (4*255*x^2 + x^3) / (5*255^2) with rounding.
  // Both endpoints map exactly, and the divisor is a constant so this folds
  // into a fixed table.
  function automatic t_led_byte gamma22(input t_led_byte x);
    logic [31:0] xw;
    logic [31:0] num;
    xw  = 32'(x);
    num = 32'd1020 * xw * xw + xw * xw * xw + 32'd162562;
    return t_led_byte'(num / 32'd325125);
  endfunction

  t_led_byte value_q;

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      value_q <= c_filament_off_value;
    end else begin
      value_q <= gamma22(i_value);
    end
  end

  assign o_value = value_q;

endmodule

// File: rtl/led_palette_fader.sv
// ---------------------------------------------------------------------------
// led_palette_fader
// Fades a palette of RGB and single-filament LEDs from its current values
// toward an accepted target palette, one bounded step per step tick.
// Optional build macro: LED_FADER_GAMMA_EN -- when defined, every output byte
// is the registered gamma-2.2 lookup of its current byte (+1 cycle latency).
//   i_clk / i_srst          : clock, synchronous active-high reset
//   i_tgt_valid/o_tgt_ready : target palette handshake
//   i_tgt_red/green/blue    : target RGB bytes, LED k at [8k+7:8k]
//   i_tgt_lumin             : target basic-LED bytes, same packing
//   o_color_led_*_value     : current RGB palette toward the PWM driver
//   o_basic_led_lumin_value : current basic palette
//   o_fade_busy             : high while the palette is not settled
// ---------------------------------------------------------------------------
module led_palette_fader
  import led_pwm_pkg::*;
#(
  parameter int parm_color_led_count = 4,
  parameter int parm_basic_led_count = 4,
  parameter int parm_FCLK            = 40_000_000,
  parameter int parm_step_period_ms  = 2,
  parameter int parm_step_size       = 4
) (
  input  logic                              i_clk,
  input  logic                              i_srst,
  input  logic                              i_tgt_valid,
  output logic                              o_tgt_ready,
  input  logic [8*parm_color_led_count-1:0] i_tgt_red,
  input  logic [8*parm_color_led_count-1:0] i_tgt_green,
  input  logic [8*parm_color_led_count-1:0] i_tgt_blue,
  input  logic [8*parm_basic_led_count-1:0] i_tgt_lumin,
  output logic [8*parm_color_led_count-1:0] o_color_led_red_value,
  output logic [8*parm_color_led_count-1:0] o_color_led_green_value,
  output logic [8*parm_color_led_count-1:0] o_color_led_blue_value,
  output logic [8*parm_basic_led_count-1:0] o_basic_led_lumin_value,
  output logic                              o_fade_busy
);

  localparam int          c_nc          = parm_color_led_count;
  localparam int          c_nb          = parm_basic_led_count;
  localparam int          c_step_cycles = parm_FCLK / 1000 * parm_step_period_ms;
  localparam logic [31:0] c_tick_reload = 32'(c_step_cycles - 1);
  localparam t_led_byte   c_step        = t_led_byte'(parm_step_size);

  logic [31:0]  tick_cnt_q, tick_cnt_d;
  logic         tick;
  t_fader_state state_q, state_d;
  logic         busy_q;
  logic         handshake;
  logic         step_en;
  logic         all_equal;

  t_led_byte red_q   [c_nc];
  t_led_byte red_d   [c_nc];
  t_led_byte green_q [c_nc];
  t_led_byte green_d [c_nc];
  t_led_byte blue_q  [c_nc];
  t_led_byte blue_d  [c_nc];
  t_led_byte lumin_q [c_nb];
  t_led_byte lumin_d [c_nb];

  t_led_byte tgt_red_q   [c_nc];
  t_led_byte tgt_red_d   [c_nc];
  t_led_byte tgt_green_q [c_nc];
  t_led_byte tgt_green_d [c_nc];
  t_led_byte tgt_blue_q  [c_nc];
  t_led_byte tgt_blue_d  [c_nc];
  t_led_byte tgt_lumin_q [c_nb];
  t_led_byte tgt_lumin_d [c_nb];

  // Free-running step timebase: only reset touches it, so handshakes never
  // shift the tick phase.
  always_comb begin
    tick       = (tick_cnt_q == 32'd0);
    tick_cnt_d = tick ? c_tick_reload : tick_cnt_q - 32'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      tick_cnt_q <= c_tick_reload;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  assign handshake = i_tgt_valid & o_tgt_ready;

  // A handshake takes priority over a coincident tick: no step that cycle.
  assign step_en = (state_q == S_FADE) && tick && !handshake;

  always_comb begin
    all_equal = 1'b1;
    for (int k = 0; k < c_nc; k++) begin
      if (red_q[k] != tgt_red_q[k] || green_q[k] != tgt_green_q[k] ||
          blue_q[k] != tgt_blue_q[k]) begin
        all_equal = 1'b0;
      end
    end
    for (int k = 0; k < c_nb; k++) begin
      if (lumin_q[k] != tgt_lumin_q[k]) begin
        all_equal = 1'b0;
      end
    end
  end

  // FSM state register; busy is registered from the next state so that it
  // always equals (state != S_IDLE).
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (handshake) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = S_FADE;
      end
      S_FADE: begin
        if (handshake) begin
          state_d = S_LOAD;
        end else if (all_equal) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    o_tgt_ready = !i_srst && (state_q != S_LOAD);
  end

  assign o_fade_busy = busy_q;

  always_comb begin
    tgt_red_d   = tgt_red_q;
    tgt_green_d = tgt_green_q;
    tgt_blue_d  = tgt_blue_q;
    tgt_lumin_d = tgt_lumin_q;
    red_d       = red_q;
    green_d     = green_q;
    blue_d      = blue_q;
    lumin_d     = lumin_q;
    if (handshake) begin
      for (int k = 0; k < c_nc; k++) begin
        tgt_red_d[k]   = i_tgt_red[8*k +: 8];
        tgt_green_d[k] = i_tgt_green[8*k +: 8];
        tgt_blue_d[k]  = i_tgt_blue[8*k +: 8];
      end
      for (int k = 0; k < c_nb; k++) begin
        tgt_lumin_d[k] = i_tgt_lumin[8*k +: 8];
      end
    end
    if (step_en) begin
      for (int k = 0; k < c_nc; k++) begin
        red_d[k]   = step_toward(red_q[k], tgt_red_q[k], c_step);
        green_d[k] = step_toward(green_q[k], tgt_green_q[k], c_step);
        blue_d[k]  = step_toward(blue_q[k], tgt_blue_q[k], c_step);
      end
      for (int k = 0; k < c_nb; k++) begin
        lumin_d[k] = step_toward(lumin_q[k], tgt_lumin_q[k], c_step);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      for (int k = 0; k < c_nc; k++) begin
        red_q[k]       <= c_filament_off_value;
        green_q[k]     <= c_filament_off_value;
        blue_q[k]      <= c_filament_off_value;
        tgt_red_q[k]   <= c_filament_off_value;
        tgt_green_q[k] <= c_filament_off_value;
        tgt_blue_q[k]  <= c_filament_off_value;
      end
      for (int k = 0; k < c_nb; k++) begin
        lumin_q[k]     <= c_filament_off_value;
        tgt_lumin_q[k] <= c_filament_off_value;
      end
    end else begin
      red_q       <= red_d;
      green_q     <= green_d;
      blue_q      <= blue_d;
      lumin_q     <= lumin_d;
      tgt_red_q   <= tgt_red_d;
      tgt_green_q <= tgt_green_d;
      tgt_blue_q  <= tgt_blue_d;
      tgt_lumin_q <= tgt_lumin_d;
    end
  end

`ifdef LED_FADER_GAMMA_EN
  for (genvar k = 0; k < c_nc; k++) begin : g_color_gamma
    led_gamma_lut u_red (
      .i_clk   (i_clk),
      .i_srst  (i_srst),
      .i_value (red_q[k]),
      .o_value (o_color_led_red_value[8*k +: 8])
    );
    led_gamma_lut u_green (
      .i_clk   (i_clk),
      .i_srst  (i_srst),
      .i_value (green_q[k]),
      .o_value (o_color_led_green_value[8*k +: 8])
    );
    led_gamma_lut u_blue (
      .i_clk   (i_clk),
      .i_srst  (i_srst),
      .i_value (blue_q[k]),
      .o_value (o_color_led_blue_value[8*k +: 8])
    );
  end
  for (genvar k = 0; k < c_nb; k++) begin : g_basic_gamma
    led_gamma_lut u_lumin (
      .i_clk   (i_clk),
      .i_srst  (i_srst),
      .i_value (lumin_q[k]),
      .o_value (o_basic_led_lumin_value[8*k +: 8])
    );
  end
`else
  for (genvar k = 0; k < c_nc; k++) begin : g_color_out
    assign o_color_led_red_value[8*k +: 8]   = red_q[k];
    assign o_color_led_green_value[8*k +: 8] = green_q[k];
    assign o_color_led_blue_value[8*k +: 8]  = blue_q[k];
  end
  for (genvar k = 0; k < c_nb; k++) begin : g_basic_out
    assign o_basic_led_lumin_value[8*k +: 8] = lumin_q[k];
  end
`endif

endmodule

// File: tb/tb_led_palette_fader.sv
// ---------------------------------------------------------------------------
// tb_led_palette_fader
// Directed bench for led_palette_fader in the default (no gamma) build.
// Clock 100 kHz equivalent, 1 ms step period -> one step tick every 100 cycles,
// step size 4, four RGB LEDs and four basic LEDs (32-bit buses).
// ---------------------------------------------------------------------------
module tb_led_palette_fader;

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic        valid = 1'b0;
  logic        ready;
  logic        busy;
  logic [31:0] tgtRed = 32'h0;
  logic [31:0] tgtGreen = 32'h0;
  logic [31:0] tgtBlue = 32'h0;
  logic [31:0] tgtLumin = 32'h0;
  logic [31:0] outRed;
  logic [31:0] outGreen;
  logic [31:0] outBlue;
  logic [31:0] outLumin;

  int checks = 0;
  int failures = 0;
  int mCnt = 99;
  int n;
  logic [7:0] exp033 [4] = '{8'h04, 8'h08, 8'h0C, 8'h10};
  logic [7:0] exp034 [3] = '{8'h04, 8'h08, 8'h0A};

  always #5 clk = ~clk;

  led_palette_fader #(
    .parm_color_led_count (4),
    .parm_basic_led_count (4),
    .parm_FCLK            (100_000),
    .parm_step_period_ms  (1),
    .parm_step_size       (4)
  ) dut (
    .i_clk                   (clk),
    .i_srst                  (srst),
    .i_tgt_valid             (valid),
    .o_tgt_ready             (ready),
    .i_tgt_red               (tgtRed),
    .i_tgt_green             (tgtGreen),
    .i_tgt_blue              (tgtBlue),
    .i_tgt_lumin             (tgtLumin),
    .o_color_led_red_value   (outRed),
    .o_color_led_green_value (outGreen),
    .o_color_led_blue_value  (outBlue),
    .o_basic_led_lumin_value (outLumin),
    .o_fade_busy             (busy)
  );

  // Expected tick phase: a step is applied on the edge after mCnt reads 0.
  always @(posedge clk) begin
    if (srst) mCnt <= 99;
    else if (mCnt == 0) mCnt <= 99;
    else mCnt <= mCnt - 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns at the negedge just after the next tick edge, with the number of
  // negedges waited.
  task automatic waitTick(output int cnt);
    cnt = 0;
    while (mCnt != 0 && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    if (mCnt != 0) begin
      checks++;
      failures++;
      $error("[TB] FAIL tick_timeout observed=%0d expected=0", mCnt);
    end
    @(negedge clk);
    cnt++;
  endtask

  task automatic waitTicks(input int num);
    int c;
    for (int i = 0; i < num; i++) waitTick(c);
  endtask

  // Offer the current targets, keeping the handshake and LOAD cycles clear of
  // a tick. Returns at the negedge where the DUT is in S_LOAD.
  task automatic applyStimulus();
    int g = 0;
    while (mCnt < 4 && g < 10) begin
      @(negedge clk);
      g++;
    end
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic doReset();
    srst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    srst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_ready", ready, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_red", outRed, 32'h0);
    checkOutput("rst_lumin", outLumin, 32'h0);
    srst = 1'b0;
    @(negedge clk);
    checkOutput("idle_ready", ready, 1'b1);

    // Fade up red0 to 0x10, ticks 100 cycles apart
    tgtRed = 32'h0000_0010;
    applyStimulus();
    checkOutput("load_ready", ready, 1'b0);
    checkOutput("load_busy", busy, 1'b1);
    checkOutput("load_red_hold", outRed, 32'h0);
    @(negedge clk);
    checkOutput("fade_ready", ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      waitTick(n);
      checkOutput("up_red", outRed, {24'h0, exp033[i]});
      if (i > 0) checkOutput("up_spacing", n, 100);
    end
    checkOutput("up_busy_hold", busy, 1'b1);
    @(negedge clk);
    checkOutput("up_busy_drop", busy, 1'b0);
    checkOutput("up_ready_idle", ready, 1'b1);

    // No overshoot: 00 -> 0A
    doReset();
    tgtRed = 32'h0000_000A;
    applyStimulus();
    for (int i = 0; i < 3; i++) begin
      waitTick(n);
      checkOutput("ovs_red", outRed, {24'h0, exp034[i]});
    end
    checkOutput("ovs_blue", outBlue, 32'h0);
    @(negedge clk);
    checkOutput("ovs_busy_drop", busy, 1'b0);

    // green1 up to FF, then down to 02 without underflow
    tgtGreen = 32'h0000_FF00;
    applyStimulus();
    waitTicks(63);
    checkOutput("g_up_63", outGreen, 32'h0000_FC00);
    waitTick(n);
    checkOutput("g_up_64", outGreen, 32'h0000_FF00);
    checkOutput("g_red_kept", outRed, 32'h0000_000A);
    tgtGreen = 32'h0000_0200;
    applyStimulus();
    waitTicks(63);
    checkOutput("g_dn_63", outGreen, 32'h0000_0300);
    waitTick(n);
    checkOutput("g_dn_64", outGreen, 32'h0000_0200);
    waitTick(n);
    checkOutput("g_dn_settled", outGreen, 32'h0000_0200);
    checkOutput("g_dn_busy", busy, 1'b0);

    // Retarget mid-fade: red0 at 08 heading to 40, new target 00
    doReset();
    tgtGreen = 32'h0;
    tgtRed = 32'h0000_0040;
    applyStimulus();
    waitTicks(2);
    checkOutput("rt_red_08", outRed, 32'h0000_0008);
    tgtRed = 32'h0;
    applyStimulus();
    checkOutput("rt_load_ready", ready, 1'b0);
    checkOutput("rt_load_red", outRed, 32'h0000_0008);
    checkOutput("rt_load_busy", busy, 1'b1);
    waitTick(n);
    checkOutput("rt_red_04", outRed, 32'h0000_0004);
    waitTick(n);
    checkOutput("rt_red_00", outRed, 32'h0);
    @(negedge clk);
    checkOutput("rt_busy_drop", busy, 1'b0);

    // Handshake on the tick cycle: no step that cycle
    tgtRed = 32'h0000_0008;
    applyStimulus();
    waitTick(n);
    checkOutput("ht_red_04", outRed, 32'h0000_0004);
    n = 0;
    while (mCnt != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    tgtRed = 32'h0;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    checkOutput("ht_no_step", outRed, 32'h0000_0004);
    checkOutput("ht_load_ready", ready, 1'b0);
    waitTick(n);
    checkOutput("ht_spacing", n, 100);
    checkOutput("ht_red_00", outRed, 32'h0);

    // Reset mid-fade
    tgtRed = 32'h0000_0040;
    tgtLumin = 32'h0080_0000;
    applyStimulus();
    waitTicks(2);
    checkOutput("mr_red_08", outRed, 32'h0000_0008);
    checkOutput("mr_lumin_08", outLumin, 32'h0008_0000);
    srst = 1'b1;
    @(negedge clk);
    checkOutput("mr_red", outRed, 32'h0);
    checkOutput("mr_lumin", outLumin, 32'h0);
    checkOutput("mr_busy", busy, 1'b0);
    checkOutput("mr_ready", ready, 1'b0);
    srst = 1'b0;
    @(negedge clk);
    checkOutput("mr_ready_after", ready, 1'b1);
    waitTick(n);
    checkOutput("mr_abandoned", outRed, 32'h0);
    checkOutput("mr_busy_after", busy, 1'b0);

    // Target equal to current palette still passes LOAD and FADE
    tgtRed = 32'h0;
    tgtLumin = 32'h0;
    applyStimulus();
    checkOutput("eq_load_ready", ready, 1'b0);
    checkOutput("eq_load_busy", busy, 1'b1);
    @(negedge clk);
    checkOutput("eq_fade_ready", ready, 1'b1);
    checkOutput("eq_fade_busy", busy, 1'b1);
    @(negedge clk);
    checkOutput("eq_idle_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
